// File: rtl/inert_pkg.sv
// Shared types and constants for the burst inertial reader.
// Sensor configuration words and the read-command builder live here.
package inert_pkg;

    typedef enum logic [2:0] {
        PWR_WAIT,
        CFG,
        IDLE,
        RD,
        PUB
    } inert_rd_state_t;

    localparam logic [15:0] CFG_CMD0 = 16'h0D02;
    localparam logic [15:0] CFG_CMD1 = 16'h1160;
    localparam logic [15:0] CFG_CMD2 = 16'h1440;
    localparam logic        READ_BIT = 1'b1;

    function automatic logic [15:0] rd_cmd(input logic [6:0] addr);
        return {READ_BIT, addr, 8'h00};
    endfunction

endpackage

// File: rtl/async_edge_det.sv
// Two-flop synchroniser followed by a registered rising-edge detector.
// Reused for any asynchronous level input (INT, lftIR, rghtIR).
module async_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise
);

    logic s1, s2, s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s3   <= 1'b0;
            rise <= 1'b0;
        end else begin
            s1   <= async_in;
            s2   <= s1;
            s3   <= s2;
            rise <= s2 & ~s3;
        end
    end

endmodule

// File: rtl/inert_burst_rd.sv
// Configures the inertial sensor, then on each data-ready edge reads
// NUM_AXES 16-bit channels over SPI and publishes them as one snapshot.
module inert_burst_rd
    import inert_pkg::*;
#(
    parameter int         NUM_AXES  = 3,
    parameter logic [6:0] BASE_ADDR = 7'h22,
    parameter bit         FAST_SIM  = 1'b1,
    parameter int         TO_W      = 12
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    INT,
    input  logic                    done,
    input  logic [15:0]             rd_data,
    output logic                    wrt,
    output logic [15:0]             cmd,
    output logic [16*NUM_AXES-1:0]  axis_data,
    output logic                    vld,
    output logic                    init_done,
    output logic                    ovr,
    output logic                    to_err
);

    localparam int              TMR_W   = FAST_SIM ? 9 : 16;
    localparam int              NB      = 2 * NUM_AXES;
    localparam logic [3:0]      K_LAST  = 4'(NB - 1);
    localparam logic [TO_W-1:0] TO_LAST = ~TO_W'(1);

    inert_rd_state_t       state;
    logic [TMR_W-1:0]      tmr;
    logic [1:0]            cfg_idx;
    logic [3:0]            k;
    logic                  pending;
    logic [TO_W-1:0]       to_cnt;
    logic [16*NUM_AXES-1:0] byte_buf, byte_buf_nxt;
    logic [15:0]           cmd_q, cmd_nxt;
    logic                  int_edge;
    logic                  busy;
    logic                  unused;

    assign unused = ^rd_data[15:8];

    async_edge_det u_int_det (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (INT),
        .rise     (int_edge)
    );

    assign busy = (state == CFG) || (state == RD);
    // Fires as the count rolls onto all-ones; a same-cycle done wins.
    assign to_err = busy && !done && (to_cnt == TO_LAST);
    assign ovr    = int_edge && ((state == RD) || (state == PUB));
    assign cmd    = cmd_nxt;

    always_comb begin
        wrt          = 1'b0;
        cmd_nxt      = cmd_q;
        byte_buf_nxt = byte_buf;
        for (int i = 0; i < NB; i++) begin
            if (k == 4'(i)) byte_buf_nxt[8*i +: 8] = rd_data[7:0];
        end
        case (state)
            PWR_WAIT: if (&tmr) begin
                wrt     = 1'b1;
                cmd_nxt = CFG_CMD0;
            end
            CFG: if (done && cfg_idx != 2'd2) begin
                wrt     = 1'b1;
                cmd_nxt = (cfg_idx == 2'd0) ? CFG_CMD1 : CFG_CMD2;
            end
            IDLE: if (int_edge || pending) begin
                wrt     = 1'b1;
                cmd_nxt = rd_cmd(BASE_ADDR);
            end
            RD: if (done && k != K_LAST) begin
                wrt     = 1'b1;
                cmd_nxt = rd_cmd(BASE_ADDR + 7'(k) + 7'd1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= PWR_WAIT;
            tmr       <= '0;
            cfg_idx   <= '0;
            k         <= '0;
            pending   <= 1'b0;
            to_cnt    <= '0;
            byte_buf  <= '0;
            cmd_q     <= '0;
            axis_data <= '0;
            vld       <= 1'b0;
            init_done <= 1'b0;
        end else begin
            vld <= 1'b0;
            if (wrt) cmd_q <= cmd_nxt;
            if (wrt) to_cnt <= '0;
            else if (busy && !done) to_cnt <= to_cnt + 1'b1;
            if (ovr) pending <= 1'b1;
            case (state)
                PWR_WAIT: begin
                    tmr <= tmr + 1'b1;
                    if (&tmr) begin
                        tmr     <= '0;
                        cfg_idx <= '0;
                        state   <= CFG;
                    end
                end
                CFG: begin
                    if (done) begin
                        if (cfg_idx == 2'd2) begin
                            init_done <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            cfg_idx <= cfg_idx + 2'd1;
                        end
                    end else if (to_err) begin
                        state <= PWR_WAIT;
                    end
                end
                IDLE: begin
                    if (int_edge || pending) begin
                        pending <= 1'b0;
                        k       <= '0;
                        state   <= RD;
                    end
                end
                RD: begin
                    if (done) begin
                        byte_buf <= byte_buf_nxt;
                        // Publish straight from the merged buffer so vld
                        // lands one clock after the final done.
                        if (k == K_LAST) begin
                            axis_data <= byte_buf_nxt;
                            vld       <= 1'b1;
                            state     <= PUB;
                        end else begin
                            k <= k + 4'd1;
                        end
                    end else if (to_err) begin
                        state <= IDLE;
                    end
                end
                PUB: state <= IDLE;
                default: state <= PWR_WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_inert_burst_rd.sv
// Directed bench: two DUTs (3 axes / 12-bit timeout, 6 axes / 4-bit timeout)
// each served by a small SPI responder model.
module tb_inert_burst_rd;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b, int_a, int_b;
    logic        done_a = 1'b0, done_b = 1'b0;
    logic [15:0] rd_data_a = '0, rd_data_b = '0;
    logic [15:0] cmd_a, cmd_b;
    logic        wrt_a, wrt_b, vld_a, vld_b;
    logic        init_done_a, init_done_b, ovr_a, ovr_b, to_err_a, to_err_b;
    logic [47:0] axis_a;
    logic [95:0] axis_b;

    int checks = 0;
    int errors = 0;

    inert_burst_rd #(.NUM_AXES(3), .BASE_ADDR(7'h22), .FAST_SIM(1'b1), .TO_W(12)) dut_a (
        .clk(clk), .rst_n(rst_a), .INT(int_a), .done(done_a), .rd_data(rd_data_a),
        .wrt(wrt_a), .cmd(cmd_a), .axis_data(axis_a), .vld(vld_a),
        .init_done(init_done_a), .ovr(ovr_a), .to_err(to_err_a)
    );

    inert_burst_rd #(.NUM_AXES(6), .BASE_ADDR(7'h22), .FAST_SIM(1'b1), .TO_W(4)) dut_b (
        .clk(clk), .rst_n(rst_b), .INT(int_b), .done(done_b), .rd_data(rd_data_b),
        .wrt(wrt_b), .cmd(cmd_b), .axis_data(axis_b), .vld(vld_b),
        .init_done(init_done_b), .ovr(ovr_b), .to_err(to_err_b)
    );

    // Cycle index since reset release; equals the power-up timer value.
    int pe_a = 0, pe_b = 0;
    always @(posedge clk or negedge rst_a) if (!rst_a) pe_a <= 0; else pe_a <= pe_a + 1;
    always @(posedge clk or negedge rst_b) if (!rst_b) pe_b <= 0; else pe_b <= pe_b + 1;

    // SPI responder + monitor for dut_a: done LAT_A clocks after each wrt,
    // read byte = register address - 0x11 + off_a.
    localparam int LAT_A = 40;
    int          cnt_a = 0;
    logic [15:0] lat_cmd_a = '0;
    logic [7:0]  off_a = 8'h00;
    logic [15:0] q_cmd_a[$];
    int          q_wrt_a[$], q_vld_a[$];
    int          n_ovr_a = 0, init_pe_a = -1;
    logic        idn_prev_a = 1'b0;

    always @(negedge clk) begin
        done_a = 1'b0;
        if (cnt_a > 0) begin
            cnt_a--;
            if (cnt_a == 0) begin
                done_a    = 1'b1;
                rd_data_a = {8'h00, 8'(lat_cmd_a[14:8]) - 8'h11 + off_a};
            end
        end
        #1;
        if (wrt_a) begin
            cnt_a     = LAT_A;
            lat_cmd_a = cmd_a;
            q_cmd_a.push_back(cmd_a);
            q_wrt_a.push_back(pe_a);
        end
        if (vld_a) q_vld_a.push_back(pe_a);
        if (ovr_a) n_ovr_a++;
        if (init_done_a && !idn_prev_a) init_pe_a = pe_a;
        idn_prev_a = init_done_a;
    end

    // Responder + monitor for dut_b, with an optional withheld done.
    localparam int LAT_B = 8;
    int          cnt_b = 0;
    logic [15:0] lat_cmd_b = '0;
    logic [15:0] drop_cmd_b = '0;
    logic        drop_en_b = 1'b0;
    logic [7:0]  off_b = 8'h00;
    logic [15:0] q_cmd_b[$];
    int          q_wrt_b[$], q_vld_b[$], q_done_b[$], q_to_b[$];

    always @(negedge clk) begin
        done_b = 1'b0;
        if (cnt_b > 0) begin
            cnt_b--;
            if (cnt_b == 0) begin
                if (drop_en_b && lat_cmd_b == drop_cmd_b) begin
                    drop_en_b = 1'b0;
                end else begin
                    done_b    = 1'b1;
                    rd_data_b = {8'h00, 8'(lat_cmd_b[14:8]) - 8'h11 + off_b};
                end
            end
        end
        #1;
        if (wrt_b) begin
            cnt_b     = LAT_B;
            lat_cmd_b = cmd_b;
            q_cmd_b.push_back(cmd_b);
            q_wrt_b.push_back(pe_b);
        end
        if (done_b) q_done_b.push_back(pe_b);
        if (vld_b) q_vld_b.push_back(pe_b);
        if (to_err_b) q_to_b.push_back(pe_b);
    end

    task automatic clear_a();
        q_cmd_a.delete();
        q_wrt_a.delete();
        q_vld_a.delete();
        n_ovr_a = 0;
    endtask

    task automatic clear_b();
        q_cmd_b.delete();
        q_wrt_b.delete();
        q_vld_b.delete();
        q_done_b.delete();
        q_to_b.delete();
    endtask

    task automatic test_reset();
        rst_a = 1'b0;
        rst_b = 1'b0;
        int_a = 1'b0;
        int_b = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        checks++;
        if (wrt_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_wrt got %b want 0", wrt_a);
        end
        checks++;
        if (cmd_a !== 16'h0000) begin
            errors++;
            $display("FAIL reset_cmd got %h want 0000", cmd_a);
        end
        checks++;
        if ({vld_a, init_done_a, ovr_a, to_err_a} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags got %b want 0000", {vld_a, init_done_a, ovr_a, to_err_a});
        end
        checks++;
        if (axis_a !== 48'h0 || axis_b !== 96'h0) begin
            errors++;
            $display("FAIL reset_axis got %h/%h want 0", axis_a, axis_b);
        end
        init_pe_a = -1;
        clear_a();
        @(negedge clk);
        rst_a = 1'b1;
        rst_b = 1'b1;
    endtask

    task automatic check_init_a(input string tag);
        for (int i = 0; i < 2000 && init_pe_a < 0; i++) @(negedge clk);
        checks++;
        if (q_cmd_a.size() != 3) begin
            errors++;
            $display("FAIL %s_ncmd got %0d want 3", tag, q_cmd_a.size());
        end else begin
            checks++;
            if ({q_cmd_a[0], q_cmd_a[1], q_cmd_a[2]} !== {16'h0D02, 16'h1160, 16'h1440}) begin
                errors++;
                $display("FAIL %s_cmds got %h %h %h want 0d02 1160 1440",
                         tag, q_cmd_a[0], q_cmd_a[1], q_cmd_a[2]);
            end
            checks++;
            if (q_wrt_a[0] != 511 || q_wrt_a[1] != 551 || q_wrt_a[2] != 591) begin
                errors++;
                $display("FAIL %s_wrt_time got %0d %0d %0d want 511 551 591",
                         tag, q_wrt_a[0], q_wrt_a[1], q_wrt_a[2]);
            end
        end
        checks++;
        if (init_pe_a != 632) begin
            errors++;
            $display("FAIL %s_init_done got %0d want 632", tag, init_pe_a);
        end
    endtask

    task automatic test_powerup();
        check_init_a("powerup");
    endtask

    task automatic test_single_frame();
        int p;
        clear_a();
        off_a = 8'h00;
        @(negedge clk);
        int_a = 1'b1;
        p = pe_a;
        for (int i = 0; i < 600 && q_vld_a.size() < 1; i++) @(negedge clk);
        int_a = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (q_cmd_a.size() != 6 || q_vld_a.size() != 1) begin
            errors++;
            $display("FAIL frame_count got %0d cmds %0d vld want 6 1", q_cmd_a.size(), q_vld_a.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (q_cmd_a[i] !== 16'hA200 + 16'(i * 256)) begin
                    errors++;
                    $display("FAIL frame_cmd%0d got %h want %h", i, q_cmd_a[i], 16'hA200 + 16'(i * 256));
                end
            end
            checks++;
            if (q_wrt_a[0] != p + 3) begin
                errors++;
                $display("FAIL int_latency got %0d want %0d", q_wrt_a[0], p + 3);
            end
            checks++;
            if (q_vld_a[0] != p + 244) begin
                errors++;
                $display("FAIL frame_vld_time got %0d want %0d", q_vld_a[0], p + 244);
            end
        end
        checks++;
        if (axis_a !== 48'h1615_1413_1211) begin
            errors++;
            $display("FAIL frame_data got %h want 161514131211", axis_a);
        end
    endtask

    task automatic test_overrun();
        clear_a();
        off_a = 8'h20;
        @(negedge clk);
        int_a = 1'b1;
        repeat (50) @(negedge clk);
        int_a = 1'b0;
        repeat (10) @(negedge clk);
        int_a = 1'b1;
        repeat (20) @(negedge clk);
        int_a = 1'b0;
        repeat (20) @(negedge clk);
        int_a = 1'b1;
        repeat (10) @(negedge clk);
        int_a = 1'b0;
        for (int i = 0; i < 1200 && q_vld_a.size() < 2; i++) @(negedge clk);
        repeat (300) @(negedge clk);
        checks++;
        if (n_ovr_a != 2) begin
            errors++;
            $display("FAIL ovr_count got %0d want 2", n_ovr_a);
        end
        checks++;
        if (q_vld_a.size() != 2 || q_cmd_a.size() != 12) begin
            errors++;
            $display("FAIL ovr_frames got %0d vld %0d cmds want 2 12", q_vld_a.size(), q_cmd_a.size());
        end else begin
            checks++;
            if (q_wrt_a[6] != q_vld_a[0] + 1 || q_cmd_a[6] !== 16'hA200) begin
                errors++;
                $display("FAIL ovr_replay got %0d %h want %0d a200", q_wrt_a[6], q_cmd_a[6], q_vld_a[0] + 1);
            end
        end
        checks++;
        if (axis_a !== 48'h3635_3433_3231) begin
            errors++;
            $display("FAIL ovr_data got %h want 363534333231", axis_a);
        end
    endtask

    task automatic test_reset_mid_frame();
        clear_a();
        @(negedge clk);
        int_a = 1'b1;
        for (int i = 0; i < 400 && q_cmd_a.size() < 3; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        #2;
        rst_a = 1'b0;
        #1;
        checks++;
        if ({wrt_a, vld_a, init_done_a, ovr_a, to_err_a} !== 5'b0 || cmd_a !== 16'h0) begin
            errors++;
            $display("FAIL midrst_outputs got %b cmd %h want 00000 0000",
                     {wrt_a, vld_a, init_done_a, ovr_a, to_err_a}, cmd_a);
        end
        checks++;
        if (axis_a !== 48'h0) begin
            errors++;
            $display("FAIL midrst_axis got %h want 0", axis_a);
        end
        int_a = 1'b0;
        repeat (3) @(negedge clk);
        clear_a();
        init_pe_a = -1;
        rst_a = 1'b1;
        check_init_a("rerun");
    endtask

    task automatic test_width();
        clear_b();
        off_b = 8'h00;
        checks++;
        if (init_done_b !== 1'b1) begin
            errors++;
            $display("FAIL width_init got %b want 1", init_done_b);
        end
        @(negedge clk);
        int_b = 1'b1;
        for (int i = 0; i < 400 && q_vld_b.size() < 1; i++) @(negedge clk);
        int_b = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (q_cmd_b.size() != 12 || q_vld_b.size() != 1) begin
            errors++;
            $display("FAIL width_count got %0d cmds %0d vld want 12 1", q_cmd_b.size(), q_vld_b.size());
        end else begin
            for (int i = 0; i < 12; i++) begin
                checks++;
                if (q_cmd_b[i] !== 16'hA200 + 16'(i * 256)) begin
                    errors++;
                    $display("FAIL width_cmd%0d got %h want %h", i, q_cmd_b[i], 16'hA200 + 16'(i * 256));
                end
            end
            checks++;
            if (q_vld_b[0] != q_done_b[11] + 1) begin
                errors++;
                $display("FAIL width_vld_time got %0d want %0d", q_vld_b[0], q_done_b[11] + 1);
            end
        end
        checks++;
        if (axis_b[80 +: 16] !== 16'h1C1B) begin
            errors++;
            $display("FAIL width_ch5 got %h want 1c1b", axis_b[80 +: 16]);
        end
        checks++;
        if (axis_b !== 96'h1C1B_1A19_1817_1615_1413_1211) begin
            errors++;
            $display("FAIL width_data got %h want 1c1b1a191817161514131211", axis_b);
        end
    endtask

    task automatic test_timeout();
        clear_b();
        drop_cmd_b = 16'hA500;
        drop_en_b  = 1'b1;
        @(negedge clk);
        int_b = 1'b1;
        for (int i = 0; i < 300 && q_to_b.size() < 1; i++) @(negedge clk);
        int_b = 1'b0;
        repeat (50) @(negedge clk);
        checks++;
        if (q_to_b.size() != 1 || q_cmd_b.size() != 4) begin
            errors++;
            $display("FAIL to_count got %0d to_err %0d cmds want 1 4", q_to_b.size(), q_cmd_b.size());
        end else begin
            checks++;
            if (q_cmd_b[3] !== 16'hA500 || q_to_b[0] != q_wrt_b[3] + 15) begin
                errors++;
                $display("FAIL to_time got %h at %0d want a500 at %0d", q_cmd_b[3], q_to_b[0], q_wrt_b[3] + 15);
            end
        end
        checks++;
        if (q_vld_b.size() != 0 || axis_b !== 96'h1C1B_1A19_1817_1615_1413_1211) begin
            errors++;
            $display("FAIL to_hold got %0d vld %h want 0 prior", q_vld_b.size(), axis_b);
        end
        off_b = 8'h40;
        @(negedge clk);
        int_b = 1'b1;
        for (int i = 0; i < 400 && q_vld_b.size() < 1; i++) @(negedge clk);
        int_b = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (q_vld_b.size() != 1 || axis_b !== 96'h5C5B_5A59_5857_5655_5453_5251) begin
            errors++;
            $display("FAIL to_recover got %0d vld %h want 1 5c5b5a595857565554535251",
                     q_vld_b.size(), axis_b);
        end
    endtask

    initial begin
        test_reset();
        test_powerup();
        test_single_frame();
        test_overrun();
        test_reset_mid_frame();
        test_width();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
